// File: rtl/hc595_pkg.sv
// Shared constants and field helpers for the 74HC595 serial-display receiver.
package hc595_pkg;

   localparam int unsigned SEG_W  = 8;
   localparam int unsigned SEL_W  = 8;
   localparam int unsigned CNT_W  = 5;
   localparam int unsigned WORD_W = SEG_W + SEL_W;

   function automatic logic [SEG_W-1:0] seg_of(input logic [WORD_W-1:0] word);
      return word[WORD_W-1:SEL_W];
   endfunction

   function automatic logic [SEL_W-1:0] sel_of(input logic [WORD_W-1:0] word);
      return word[SEL_W-1:0];
   endfunction

endpackage

// File: rtl/hc595_rx_sync_edge.sv
// Pin synchroniser with a rising-edge detector that arms only after the
// synchronised level has been seen low once since reset.
module sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pin_i,
   output logic level_o,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   armed_q;
   logic                   rise_q;

   // Chain resets to ones so the reset value itself never counts as "seen low";
   // a pin held high through reset therefore cannot produce an edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q  <= '1;
         prev_q  <= 1'b1;
         armed_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], pin_i};
         prev_q  <= sync_q[SYNC_STAGES-1];
         armed_q <= armed_q | ~sync_q[SYNC_STAGES-1];
         rise_q  <= armed_q & sync_q[SYNC_STAGES-1] & ~prev_q;
      end
   end

   // level_o is the registered sample aligned with rise_o.
   assign level_o = prev_q;
   assign rise_o  = rise_q;

endmodule

// File: rtl/hc595_rx.sv
// Far-end receiver of the 74HC595 display link: shifts DS on SH_CP, latches on
// ST_CP, decodes segment/select bytes into a per-digit frame buffer.
module hc595_rx
   import hc595_pkg::*;
#(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned NUM_DIG     = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     sh_cp_i,
   input  logic                     st_cp_i,
   input  logic                     ds_i,
   output logic [DATA_W-1:0]        word_o,
   output logic                     word_vld_o,
   output logic                     len_err_o,
   output logic [NUM_DIG*SEG_W-1:0] frame_o,
   output logic                     frame_upd_o
);

   logic             sh_rise, st_rise, ds_lvl;
   logic [1:0]       unused_lvl;

   logic [DATA_W-1:0]        shreg_q, sh_next;
   logic [CNT_W-1:0]         cnt_q, cnt_next;
   logic [DATA_W-1:0]        word_q;
   logic                     vld_q, err_q, upd_q;
   logic [SEG_W-1:0]         dig_buf [NUM_DIG];
   logic [NUM_DIG-1:0]       scan_q;
   logic [NUM_DIG*SEG_W-1:0] frame_q;

   logic             len_bad, wr_en, mask_full;
   logic [SEG_W-1:0] seg;
   logic [SEL_W-1:0] sel;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sh (
      .clk_i(clk_i), .rst_i(rst_i), .pin_i(sh_cp_i),
      .level_o(unused_lvl[0]), .rise_o(sh_rise)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_st (
      .clk_i(clk_i), .rst_i(rst_i), .pin_i(st_cp_i),
      .level_o(unused_lvl[1]), .rise_o(st_rise)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ds (
      .clk_i(clk_i), .rst_i(rst_i), .pin_i(ds_i),
      .level_o(ds_lvl), .rise_o()
   );

   // Shift is resolved before the latch so a coincident edge includes the new bit.
   always_comb begin
      sh_next  = shreg_q;
      cnt_next = cnt_q;
      if (sh_rise) begin
         sh_next  = {shreg_q[DATA_W-2:0], ds_lvl};
         cnt_next = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      end
      len_bad   = (cnt_next != CNT_W'(DATA_W));
      wr_en     = st_rise & ~len_bad;
      seg       = seg_of(WORD_W'(sh_next));
      sel       = sel_of(WORD_W'(sh_next));
      mask_full = &scan_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shreg_q <= '0;
         cnt_q   <= '0;
         word_q  <= '0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
         upd_q   <= 1'b0;
         scan_q  <= '0;
         frame_q <= '0;
         for (int unsigned d = 0; d < NUM_DIG; d++) dig_buf[d] <= '0;
      end else begin
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
         upd_q   <= 1'b0;
         shreg_q <= sh_next;
         cnt_q   <= cnt_next;
         if (st_rise) begin
            word_q <= sh_next;
            vld_q  <= 1'b1;
            err_q  <= len_bad;
            cnt_q  <= '0;
         end
         if (mask_full) begin
            for (int unsigned d = 0; d < NUM_DIG; d++)
               frame_q[SEG_W*d +: SEG_W] <= dig_buf[d];
            upd_q  <= 1'b1;
            scan_q <= '0;
         end
         // Later per-bit assignment wins, so a write in the dump cycle re-marks its digit.
         if (wr_en) begin
            for (int unsigned d = 0; d < NUM_DIG; d++) begin
               if (!sel[d]) begin
                  dig_buf[d] <= seg;
                  scan_q[d]  <= 1'b1;
               end
            end
         end
      end
   end

   assign word_o      = word_q;
   assign word_vld_o  = vld_q;
   assign len_err_o   = err_q;
   assign frame_o     = frame_q;
   assign frame_upd_o = upd_q;

endmodule

// File: tb/tb_hc595_rx.sv
// Scoreboard bench for hc595_rx: directed words pushed with expected results,
// an independent monitor checks every word_vld_o / frame_upd_o pulse.
module tb_hc595_rx;

   logic        clk = 1'b0;
   logic        rst_i, sh_cp_i, st_cp_i, ds_i;
   logic [15:0] word_o;
   logic        word_vld_o, len_err_o, frame_upd_o;
   logic [63:0] frame_o;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_vld_cyc = -10;

   logic [16:0] wq [$];
   logic [63:0] fq [$];

   logic [15:0] sh_m;
   logic [7:0]  buf_m [8];
   logic [7:0]  mask_m;

   hc595_rx #(.DATA_W(16), .NUM_DIG(8), .SYNC_STAGES(2)) dut (
      .clk_i(clk), .rst_i(rst_i), .sh_cp_i(sh_cp_i), .st_cp_i(st_cp_i), .ds_i(ds_i),
      .word_o(word_o), .word_vld_o(word_vld_o), .len_err_o(len_err_o),
      .frame_o(frame_o), .frame_upd_o(frame_upd_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents a pulse.
   always @(posedge clk) begin
      logic [16:0] we;
      logic [63:0] fe;
      #1;
      if (word_vld_o) begin
         last_vld_cyc = cyc;
         if (wq.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_word got=%h expected=none", word_o);
         end else begin
            we = wq.pop_front();
            check("word", {48'd0, word_o}, {48'd0, we[15:0]});
            check("len_err", {63'd0, len_err_o}, {63'd0, we[16]});
         end
      end
      if (frame_upd_o) begin
         if (fq.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_frame got=%h expected=none", frame_o);
         end else begin
            fe = fq.pop_front();
            check("frame", frame_o, fe);
            check("frame_upd_delay", 64'(cyc - last_vld_cyc), 64'd1);
         end
      end
   end

   task automatic waitn(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      sh_m   = '0;
      mask_m = '0;
      for (int d = 0; d < 8; d++) buf_m[d] = '0;
   endtask

   task automatic shift_bit(input logic b);
      ds_i = b;
      waitn(5);
      sh_cp_i = 1'b1;
      waitn(5);
      sh_cp_i = 1'b0;
   endtask

   task automatic send_word(input logic [63:0] bits, input int n, input bit coinc);
      int  cnt;
      bit  err;
      int  lat;
      logic [63:0] fr;
      for (int i = n - 1; i >= 0; i--) sh_m = {sh_m[14:0], bits[i]};
      cnt = (n > 31) ? 31 : n;
      err = (cnt != 16);
      wq.push_back({err, sh_m});
      if (!err) begin
         for (int d = 0; d < 8; d++)
            if (!sh_m[d]) begin buf_m[d] = sh_m[15:8]; mask_m[d] = 1'b1; end
         if (mask_m == 8'hFF) begin
            for (int d = 0; d < 8; d++) fr[8*d +: 8] = buf_m[d];
            fq.push_back(fr);
            mask_m = '0;
         end
      end
      for (int i = n - 1; i >= (coinc ? 1 : 0); i--) shift_bit(bits[i]);
      if (coinc) begin
         ds_i = bits[0];
         waitn(5);
         sh_cp_i = 1'b1;
      end else begin
         waitn(5);
      end
      st_cp_i = 1'b1;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (word_vld_o) begin lat = k; break; end
      end
      check("vld_latency", 64'(lat), 64'd4);
      waitn(3);
      sh_cp_i = 1'b0;
      st_cp_i = 1'b0;
      waitn(6);
   endtask

   initial begin
      rst_i = 1'b1; sh_cp_i = 1'b1; st_cp_i = 1'b0; ds_i = 1'b0;
      model_reset();
      waitn(100);
      rst_i = 1'b0;
      waitn(20);
      check("rst_word", {48'd0, word_o}, 64'd0);
      check("rst_len_err", {63'd0, len_err_o}, 64'd0);
      check("rst_frame", frame_o, 64'd0);
      sh_cp_i = 1'b0;
      waitn(10);

      send_word(64'hC0FE, 16, 1'b0);

      send_word(64'h11FD, 16, 1'b0);
      send_word(64'h22FB, 16, 1'b0);
      send_word(64'h33F7, 16, 1'b0);
      send_word(64'h44EF, 16, 1'b0);
      send_word(64'h55DF, 16, 1'b0);
      send_word(64'h66BF, 16, 1'b0);
      send_word(64'hA0FE, 16, 1'b0);
      send_word(64'h777F, 16, 1'b0);
      check("frame_first", frame_o, 64'h77665544332211A0);

      send_word(64'h6EFE, 15, 1'b0);
      check("short_word", {48'd0, word_o}, 64'hEEFE);
      send_word(64'hAB_CDEF_12FE, 40, 1'b0);
      send_word(64'h1234_5678_EEFE, 48, 1'b0);

      send_word(64'h1FFD, 16, 1'b0);
      send_word(64'h2FFB, 16, 1'b0);
      send_word(64'h3FF7, 16, 1'b0);
      send_word(64'h4FEF, 16, 1'b0);
      send_word(64'h5FDF, 16, 1'b0);
      send_word(64'h6FBF, 16, 1'b0);
      send_word(64'h7F7F, 16, 1'b0);
      send_word(64'h5AFE, 16, 1'b1);
      check("frame_second", frame_o, 64'h7F6F5F4F3F2F1F5A);

      for (int i = 7; i >= 0; i--) shift_bit(i[0]);
      rst_i = 1'b1;
      waitn(5);
      rst_i = 1'b0;
      model_reset();
      waitn(10);
      check("midrst_word", {48'd0, word_o}, 64'd0);
      check("midrst_frame", frame_o, 64'd0);
      send_word(64'h3CFB, 16, 1'b0);
      check("midrst_frame_hold", frame_o, 64'd0);
      send_word(64'h9900, 16, 1'b0);
      check("frame_all_sel", frame_o, 64'h9999999999999999);

      waitn(20);
      check("word_queue_drained", 64'(wq.size()), 64'd0);
      check("frame_queue_drained", 64'(fq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hc595_rx.md
# hc595_rx

Serial-display receiver: the far end of the three-wire 74HC595 link (SH_CP, ST_CP, DS) that the frequency meter drives. It synchronises the three pins into `clk_i`, shifts DS on SH_CP rising edges and latches the word on ST_CP rising edges. It decodes each latched word into segment/digit-select bytes and maintains a per-digit frame buffer. It serves as the on-chip display model/checker and as the front end of a remote display board.

## Interface
- `DATA_W`, 16: bits per latched word; `[15:8]` segment byte, `[7:0]` digit select
- `NUM_DIG`, 8: digits tracked; ≤ 8
- `SYNC_STAGES`, 2: synchroniser depth, ≥ 2
- `clk_i`  in  1  system clock
- `rst_i`  in  1  synchronous, active-high reset
- `sh_cp_i`  in  1  shift clock pin, asynchronous
- `st_cp_i`  in  1  storage/latch clock pin, asynchronous
- `ds_i`  in  1  serial data pin, asynchronous, MSB first
- `word_o`  out  DATA_W  last latched word
- `word_vld_o`  out  1  one-cycle pulse, `word_o` updated
- `len_err_o`  out  1  one-cycle pulse with `word_vld_o` when bit count ≠ DATA_W
- `frame_o`  out  NUM_DIG*8  segment bytes; digit d at `[8d+7:8d]`
- `frame_upd_o`  out  1  one-cycle pulse, `frame_o` refreshed

## Operation
- Each pin passes through SYNC_STAGES flops. Rising edge = last stage 1 and previous-cycle value 0.
- Edge detectors arm only after the synchronised level has been seen low once after reset. A pin held high through reset release yields no edge.
- SH_CP edge:
  - `shreg <= {shreg[DATA_W-2:0], ds_s}`, where `ds_s` is the DS sample from the same synchroniser stage.
  - `bit_cnt` increments, saturating at 31 (5 bits).
- ST_CP edge:
  - `word_o <= shreg`; pulse `word_vld_o`.
  - `len_err_o` = `(bit_cnt != DATA_W)`.
  - `bit_cnt` clears; `shreg` is kept.
- SH_CP and ST_CP edges in the same cycle: the shift happens first, so the latched word and count include the new bit.
- Frame update, only on a latch with no length error:
  - Select is active-low. For every d < NUM_DIG with `sel[d]==0`, `buf[d] <= seg` and `scan_mask[d] <= 1`.
  - `sel == 8'hFF`: no write.
  - Several zero bits write all the selected digits.
- When `scan_mask` is all ones:
  - next cycle `frame_o <= buf` and `frame_upd_o` pulses;
  - `scan_mask` clears in that cycle;
  - a write landing in that same cycle is applied to `buf` and sets its bit in the cleared mask.
- A latch with a length error updates `word_o` only; the buffer and mask are untouched.
- Reset, anywhere mid-word: all state clears, edge detectors disarm, and no pulses are issued for partial words.

## Timing
- Reset values: `word_o`=0, `word_vld_o`=0, `len_err_o`=0, `frame_o`=0, `frame_upd_o`=0; internal `shreg`, `buf`, `scan_mask`, `bit_cnt` all 0.
- Pin-to-detect latency: SYNC_STAGES+1 cycles.
- `word_vld_o`: SYNC_STAGES+2 cycles after the ST_CP pin edge (4 at the default).
- `frame_upd_o`: 1 cycle after the completing latch's `word_vld_o`.
- Source requirements:
  - SH_CP high and low phases ≥ SYNC_STAGES+1 `clk_i` cycles.
  - DS stable from SYNC_STAGES+1 cycles before to 1 cycle after the SH_CP rising edge.
- Throughput: one latch per 2·(SYNC_STAGES+1) cycles minimum.

## Structure
- Package `hc595_pkg`:
  - constants `SEG_W=8`, `SEL_W=8`, `CNT_W=5`;
  - function `seg_of(word)` / `sel_of(word)` for the field split.
- Sub-module `sync_edge`: a SYNC_STAGES synchroniser plus armed rising-edge detector; outputs `level_o` and `rise_o`.
  - one instance each for SH_CP and ST_CP;
  - DS uses `level_o` only.
- Top level: shift register, counter, latch, frame buffer, scan mask.

## Test plan
- Reset held 100 cycles with `sh_cp_i`=1 → no pulses after release; all outputs 0.
- 16 bits of 0xC0FE shifted (SH_CP 5 cycles high, 5 low), then ST_CP → `word_o`=0xC0FE, `word_vld_o` 4 cycles after the ST_CP edge, no `len_err_o`, `buf[0]`=0xC0.
- Words 0xXX_FE, 0xXX_FD … 0xXX_7F with distinct segment bytes → one `frame_upd_o`; `frame_o` holds all 8 bytes in digit order.
- 15 bits then ST_CP → `len_err_o` pulse; buffer and mask unchanged. 40 bits then ST_CP → `len_err_o` pulse, count saturates at 31 with no wrap.
- Coincident SH_CP and ST_CP edges on the 16th bit → word includes that bit, no error.
- `rst_i` asserted after 8 bits, then a full 16-bit word → correct word, no error, no stale frame data.
